spi_input_conditioner: RTL and testbench
========================================

# spi_input_conditioner

Front end for the SPI slave datapath. It sits between the raw SPI pins (SCLK, CS, MOSI) and the SPI control state machine / shift register. Each of the three asynchronous inputs is synchronized, debounced and edge-detected. The block delivers clean levels plus single-cycle `sclk_pos` / `sclk_neg` / `cs_fall` / `cs_rise` strobes in the `clk` domain. SCLK edge strobes are gated while the chip is deselected, so the downstream bit counter never advances outside a frame.

## Interface
- `WAIT_TIME`, default 3: consecutive mismatching samples, beyond the first, required before a conditioned level changes. Legal range 0..(2^COUNT_WIDTH − 1).
- `COUNT_WIDTH`, default 3: width of each channel's debounce counter.
- `clk`  in  1: system clock; all state changes on its rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `sclk_raw`  in  1: SPI clock pin, asynchronous.
- `cs_raw`  in  1: SPI chip select pin, active-low, asynchronous.
- `mosi_raw`  in  1: SPI data-in pin, asynchronous.
- `sclk_cond`  out  1: debounced SCLK level.
- `sclk_pos`  out  1: one-cycle strobe on a committed SCLK 0→1 while selected.
- `sclk_neg`  out  1: one-cycle strobe on a committed SCLK 1→0 while selected.
- `cs_cond`  out  1: debounced CS level (1 = deselected).
- `cs_fall`  out  1: one-cycle strobe on a committed CS 1→0 (frame start).
- `cs_rise`  out  1: one-cycle strobe on a committed CS 0→1 (frame end).
- `mosi_cond`  out  1: debounced MOSI level.

## Operation
- There are three identical channels: sclk, cs and mosi. Each channel contains:
  - a 2-flop synchronizer `sync0 → sync1`,
  - a conditioned register `cond`,
  - a `COUNT_WIDTH`-bit counter `cnt`.
- Per-channel rule at each clock edge, evaluated in priority order:
  1. If `sync1 == cond`: `cnt <= 0`.
  2. Else if `cnt == WAIT_TIME`: `cond <= sync1`, `cnt <= 0`, and the channel's edge flag for this cycle is set.
  3. Else: `cnt <= cnt + 1`.
- Counter arithmetic:
  - The counter never exceeds `WAIT_TIME`, so it cannot wrap.
  - Any matching sample clears it. A glitch therefore restarts the count; counts do not accumulate across glitches.
- Edge outputs are registered and high for exactly one cycle, the cycle following the commit edge:
  - `sclk_pos <= commit_sclk & sync1_sclk & ~cs_cond`
  - `sclk_neg <= commit_sclk & ~sync1_sclk & ~cs_cond`
  - `cs_fall <= commit_cs & ~sync1_cs`
  - `cs_rise <= commit_cs & sync1_cs`
- Gating uses the pre-edge value of `cs_cond`. Consequences:
  - An SCLK edge committed in the same cycle that CS commits low is suppressed.
  - An SCLK edge committed in the same cycle that CS commits high is passed.
- MOSI has no edge strobes.
- Reset values, applied asynchronously when `rst_n` = 0:
  - all `sync0`/`sync1` and `cond`: sclk 0, cs 1, mosi 0;
  - all counters 0;
  - all strobes 0.
  - Outputs after reset: `sclk_cond` = 0, `cs_cond` = 1, `mosi_cond` = 0, and all strobes 0.
- Reset mid-debounce discards the pending change. After release, a held raw value re-enters the full latency.

## Timing
- A raw level is first sampled at edge E0, and `sync1` takes it at E1.
- `cond` updates at edge E0 + WAIT_TIME + 2. The matching strobe is high from that edge until the next edge.
- Latency with the default `WAIT_TIME` = 3: 5 clocks. With `WAIT_TIME` = 0: 2 clocks (pure synchronizer).
- A raw pulse seen by fewer than WAIT_TIME+1 consecutive `sync1` samples is rejected: no `cond` change and no strobe.
- Minimum SCLK half-period for lossless operation is WAIT_TIME+1 clk cycles. Faster SCLK is filtered out and is not recovered.
- There is no backpressure. Strobes are unconditional and are never stretched or queued.

## Test plan
- Reset (`WAIT_TIME` = 3): hold `rst_n` = 0 with all raw inputs toggling → `sclk_cond` = 0, `cs_cond` = 1, `mosi_cond` = 0, all strobes 0. Release → outputs stay unchanged until 5 cycles after a raw change.
- Clean frame (`WAIT_TIME` = 3): drive `cs_raw` = 0, then 8 SCLK periods of 10 clk high / 10 clk low → one `cs_fall`, exactly 8 `sclk_pos` and 8 `sclk_neg` strobes, each 1 cycle wide. The first `sclk_pos` comes 5 cycles after the first SCLK rise.
- Glitch rejection: with CS low and SCLK low, drive 3-cycle `sclk_raw` pulses (4 samples counts as legal) → no strobes and `sclk_cond` stays 0. A 4-cycle pulse → one `sclk_pos` and one `sclk_neg`.
- Deselected gating: `cs_raw` = 1, toggle SCLK with 10-cycle halves → `sclk_cond` follows, `sclk_pos`/`sclk_neg` stay 0.
- Simultaneous commit: `cs_raw` falls and `sclk_raw` rises on the same clk edge → `cs_fall` and `cs_cond` = 0 at edge +5, with no `sclk_pos`. The next SCLK rise does strobe.
- Mid-debounce reset: `mosi_raw` 0→1, assert `rst_n` = 0 three cycles later for 2 cycles, hold `mosi_raw` = 1 → `mosi_cond` rises exactly 5 cycles after release.

Source files
------------

// File: rtl/spi_input_conditioner_if.sv
// spi_input_conditioner_if: raw SPI pins in, conditioned levels and strobes out.
interface spi_input_conditioner_if;
  logic sclk_raw, cs_raw, mosi_raw;
  logic sclk_cond, sclk_pos, sclk_neg;
  logic cs_cond, cs_fall, cs_rise;
  logic mosi_cond;
  modport master (
    output sclk_raw, cs_raw, mosi_raw,
    input  sclk_cond, sclk_pos, sclk_neg, cs_cond, cs_fall, cs_rise, mosi_cond
  );
  modport slave (
    input  sclk_raw, cs_raw, mosi_raw,
    output sclk_cond, sclk_pos, sclk_neg, cs_cond, cs_fall, cs_rise, mosi_cond
  );
endinterface

// File: rtl/spi_input_conditioner.sv
// spi_input_conditioner: synchronize, debounce and edge-detect SCLK/CS/MOSI.
module spi_input_conditioner #(
  parameter int WAIT_TIME   = 3,
  parameter int COUNT_WIDTH = 3
) (
  input logic clk,
  input logic rst_n,
  spi_input_conditioner_if.slave bus
);
  // channel index: 0 = sclk, 1 = cs, 2 = mosi; cs idles deselected (high)
  localparam logic [2:0] RST_VAL = 3'b010;
  localparam logic [COUNT_WIDTH-1:0] WAIT_CNT = COUNT_WIDTH'(WAIT_TIME);
  logic [2:0] raw, sync0_q, sync1_q, cond_q, cond_d, commit;
  logic [COUNT_WIDTH-1:0] cnt_q [3];
  logic [COUNT_WIDTH-1:0] cnt_d [3];
  logic [3:0] strb_q, strb_d;
  assign raw = {bus.mosi_raw, bus.cs_raw, bus.sclk_raw};
  always_comb begin
    for (int c = 0; c < 3; c++) begin
      commit[c] = (sync1_q[c] != cond_q[c]) && (cnt_q[c] == WAIT_CNT);
      cond_d[c] = commit[c] ? sync1_q[c] : cond_q[c];
      cnt_d[c]  = (sync1_q[c] == cond_q[c] || commit[c]) ? '0 : cnt_q[c] + COUNT_WIDTH'(1);
    end
    // sclk gating looks at cs_cond before this cycle's cs commit
    strb_d = {commit[0] & sync1_q[0] & ~cond_q[1],
              commit[0] & ~sync1_q[0] & ~cond_q[1],
              commit[1] & ~sync1_q[1],
              commit[1] & sync1_q[1]};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync0_q <= RST_VAL;
      sync1_q <= RST_VAL;
      cond_q  <= RST_VAL;
      strb_q  <= '0;
      for (int c = 0; c < 3; c++) cnt_q[c] <= '0;
    end else begin
      sync0_q <= raw;
      sync1_q <= sync0_q;
      cond_q  <= cond_d;
      cnt_q   <= cnt_d;
      strb_q  <= strb_d;
    end
  end
  assign bus.sclk_cond = cond_q[0];
  assign bus.cs_cond   = cond_q[1];
  assign bus.mosi_cond = cond_q[2];
  assign {bus.sclk_pos, bus.sclk_neg, bus.cs_fall, bus.cs_rise} = strb_q;
endmodule

// File: tb/tb_spi_input_conditioner.sv
// tb_spi_input_conditioner: directed stimulus with a strobe scoreboard keyed by cycle.
module tb_spi_input_conditioner;
  localparam logic [3:0] POS = 4'b1000, NEG = 4'b0100, FALL = 4'b0010, RISE = 4'b0001;
  typedef struct {logic [3:0] kind; int cyc;} ev_t;
  logic clk = 0;
  logic rst_n = 0;
  int cyc = 0;
  int errors = 0;
  int checks = 0;
  ev_t sb[$];
  logic [3:0] obs;
  logic [7:0] data;
  spi_input_conditioner_if b ();
  spi_input_conditioner #(.WAIT_TIME(3), .COUNT_WIDTH(3)) dut (.clk(clk), .rst_n(rst_n), .bus(b));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign obs = {b.sclk_pos, b.sclk_neg, b.cs_fall, b.cs_rise};
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, o, e, cyc);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  // a raw change driven now commits WAIT_TIME+2 edges after the next edge
  task automatic push(input logic [3:0] k);
    ev_t e;
    e.kind = k;
    e.cyc = cyc + 6;
    sb.push_back(e);
  endtask
  task automatic chk_levels(input string tag, input logic s, input logic c, input logic m);
    chk({tag, "_sclk"}, b.sclk_cond, s);
    chk({tag, "_cs"}, b.cs_cond, c);
    chk({tag, "_mosi"}, b.mosi_cond, m);
  endtask
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      checks++;
      errors++;
      $error("FAIL missed_strobe: observed=0 expected=%0h at cycle %0d", sb[0].kind, sb[0].cyc);
      void'(sb.pop_front());
    end
    if (obs != 4'b0) begin
      if (sb.size() == 0) chk("unexpected_strobe", obs, 4'b0);
      else begin
        chk("strobe_kind", obs, sb[0].kind);
        chk("strobe_cycle", cyc, sb[0].cyc);
        void'(sb.pop_front());
      end
    end
  end
  initial begin
    b.sclk_raw = 0; b.cs_raw = 1; b.mosi_raw = 0;
    step(1);
    for (int i = 0; i < 6; i++) begin
      {b.sclk_raw, b.cs_raw, b.mosi_raw} = 3'($urandom_range(0, 7));
      step(1);
      chk_levels("rst", 0, 1, 0);
      chk("rst_strobes", obs, 4'b0);
    end
    b.sclk_raw = 0; b.cs_raw = 1; b.mosi_raw = 0;
    step(2);
    rst_n = 1;
    step(10);
    chk_levels("post_rst", 0, 1, 0);
    b.mosi_raw = 1;
    step(5);
    chk("mosi_lat_early", b.mosi_cond, 0);
    step(1);
    chk("mosi_lat", b.mosi_cond, 1);
    b.mosi_raw = 0;
    step(10);
    // clean frame with data on MOSI
    data = 8'hA5;
    b.cs_raw = 0; push(FALL);
    step(10);
    chk("frame_cs", b.cs_cond, 0);
    for (int i = 0; i < 8; i++) begin
      b.sclk_raw = 1; push(POS);
      step(10);
      b.sclk_raw = 0; b.mosi_raw = data[i]; push(NEG);
      step(10);
      chk("frame_mosi", b.mosi_cond, data[i]);
    end
    b.cs_raw = 1; push(RISE);
    step(10);
    chk("frame_end_cs", b.cs_cond, 1);
    // glitch rejection while selected
    b.cs_raw = 0; push(FALL);
    step(10);
    for (int i = 0; i < 3; i++) begin
      b.sclk_raw = 1;
      step(3);
      b.sclk_raw = 0;
      step(10);
      chk("glitch_sclk", b.sclk_cond, 0);
    end
    b.sclk_raw = 1; push(POS);
    step(4);
    b.sclk_raw = 0; push(NEG);
    step(10);
    chk("min_pulse_sclk", b.sclk_cond, 0);
    b.cs_raw = 1; push(RISE);
    step(10);
    // deselected: level follows, no strobes
    for (int i = 0; i < 4; i++) begin
      b.sclk_raw = ~b.sclk_raw;
      step(10);
      chk("desel_sclk", b.sclk_cond, b.sclk_raw);
    end
    // simultaneous CS fall and SCLK rise: sclk_pos suppressed
    b.cs_raw = 0; b.sclk_raw = 1; push(FALL);
    step(5);
    chk("sim_cs_early", b.cs_cond, 1);
    step(1);
    chk("sim_cs", b.cs_cond, 0);
    chk("sim_sclk", b.sclk_cond, 1);
    step(4);
    b.sclk_raw = 0; push(NEG);
    step(10);
    b.sclk_raw = 1; push(POS);
    step(10);
    // simultaneous CS rise and SCLK fall: sclk_neg passes
    b.cs_raw = 1; b.sclk_raw = 0; push(NEG | RISE);
    step(10);
    chk_levels("sim_rise", 0, 1, b.mosi_raw);
    // reset mid-debounce discards the pending change
    b.mosi_raw = 0;
    step(10);
    b.mosi_raw = 1;
    step(3);
    rst_n = 0;
    step(2);
    chk("mid_rst_mosi", b.mosi_cond, 0);
    rst_n = 1;
    step(5);
    chk("mid_rst_early", b.mosi_cond, 0);
    step(1);
    chk("mid_rst_mosi_rise", b.mosi_cond, 1);
    step(10);
    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
